// File: rtl/pim_cmd_scheduler.sv
// PIM command queue and sequencer: buffers {mode,row,col} commands and plays each one
// out as an enable/mode/step/address sequence towards the eFlash row/column drivers.
module pim_cmd_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STEPS_READ   = 4,
    parameter int STEPS_PGM    = 8,
    parameter int STEPS_MAC    = 12,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_mode_i,
    input  logic [6:0] cmd_row_i,
    input  logic [8:0] cmd_col_i,
    input  logic       inbuf_full_i,
    input  logic       abort_i,
    input  logic       err_clr_i,
    output logic       pim_en_o,
    output logic [2:0] pim_mode_o,
    output logic [3:0] exec_cnt_o,
    output logic [6:0] row_addr7_o,
    output logic [8:0] col_addr9_o,
    output logic       out_rd_en_o,
    output logic       done_o,
    output logic       busy_o,
    output logic [4:0] fifo_count_o,
    output logic       err_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [2:0] MODE_PGM   = 3'd1;
    localparam logic [2:0] MODE_ERASE = 3'd2;
    localparam logic [2:0] MODE_READ  = 3'd3;
    localparam logic [2:0] MODE_MAC   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] mode;
        logic [6:0] row;
        logic [8:0] col;
    } cmd_t;

    function automatic logic [3:0] last_step(input logic [2:0] m);
        case (m)
            MODE_READ: last_step = 4'(STEPS_READ - 1);
            MODE_MAC:  last_step = 4'(STEPS_MAC - 1);
            default:   last_step = 4'(STEPS_PGM - 1);
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic [2:0]      mode_q, mode_d;
    logic [6:0]      row_q, row_d;
    logic [8:0]      col_q, col_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            pim_en_q, pim_en_d;
    logic [2:0]      pim_mode_q, pim_mode_d;
    logic            rd_en_q, rd_en_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            push;
    logic            pop;
    logic            err_set;
    logic            head_legal;
    cmd_t            head;
    cmd_t            fifo_mem [FIFO_DEPTH];

    // Ready is registered, so a full FIFO refuses a push even while it is being popped.
    assign push = cmd_valid_i & ready_q & ~abort_i;
    assign head = fifo_mem[rd_ptr_q];
    assign head_legal = (head.mode >= MODE_PGM) && (head.mode <= MODE_MAC);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_mode_i, cmd_row_i, cmd_col_i};
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        err_set = 1'b0;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    pop    = 1'b1;
                    mode_d = head.mode;
                    row_d  = head.row;
                    col_d  = head.col;
                    if (!head_legal) begin
                        err_set = 1'b1;
                    end else if (head.mode == MODE_MAC && !inbuf_full_i) begin
                        state_d = S_WAIT_IN;
                        wait_d  = '0;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_WAIT_IN: begin
                if (inbuf_full_i) begin
                    state_d = S_EXEC;
                    cnt_d   = 4'd0;
                end else if (wait_q == WW'(WAIT_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == last_step(mode_q)) begin
                    state_d = (mode_q == MODE_READ || mode_q == MODE_MAC) ? S_DRAIN : S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other event, including err updates.
        if (abort_i) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            err_set = 1'b0;
        end
        if (state_d != S_EXEC) begin
            cnt_d = 4'd0;
        end

        err_d    = abort_i ? err_q : (err_set | (err_q & ~err_clr_i));
        wr_ptr_d = abort_i ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = abort_i ? '0 : rd_ptr_q + PW'(pop);
        count_d  = abort_i ? 5'd0 : count_q + 5'(push) - 5'(pop);
        ready_d  = count_d < 5'(FIFO_DEPTH);

        pim_en_d   = (state_d == S_EXEC);
        pim_mode_d = (state_d == S_IDLE) ? 3'd0 : mode_d;
        rd_en_d    = (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE) || (count_d != 5'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            mode_q     <= 3'd0;
            row_q      <= 7'd0;
            col_q      <= 9'd0;
            cnt_q      <= 4'd0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            pim_en_q   <= 1'b0;
            pim_mode_q <= 3'd0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            pim_en_q   <= pim_en_d;
            pim_mode_q <= pim_mode_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign pim_en_o     = pim_en_q;
    assign pim_mode_o   = pim_mode_q;
    assign exec_cnt_o   = cnt_q;
    assign row_addr7_o  = row_q;
    assign col_addr9_o  = col_q;
    assign out_rd_en_o  = rd_en_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// Bench for pim_cmd_scheduler: directed scenarios plus randomized command streams checked
// against a queue-based model of which commands must execute, in what order, for how many steps.
module tb_pim_cmd_scheduler;
    localparam int FIFO_DEPTH   = 4;
    localparam int STEPS_READ   = 4;
    localparam int STEPS_PGM    = 8;
    localparam int STEPS_MAC    = 12;
    localparam int WAIT_TIMEOUT = 255;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i, cmd_ready_o;
    logic [2:0] cmd_mode_i;
    logic [6:0] cmd_row_i;
    logic [8:0] cmd_col_i;
    logic       inbuf_full_i, abort_i, err_clr_i;
    logic       pim_en_o;
    logic [2:0] pim_mode_o;
    logic [3:0] exec_cnt_o;
    logic [6:0] row_addr7_o;
    logic [8:0] col_addr9_o;
    logic       out_rd_en_o, done_o, busy_o, err_o;
    logic [4:0] fifo_count_o;

    pim_cmd_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mode_i(cmd_mode_i), .cmd_row_i(cmd_row_i), .cmd_col_i(cmd_col_i),
        .inbuf_full_i(inbuf_full_i), .abort_i(abort_i), .err_clr_i(err_clr_i),
        .pim_en_o(pim_en_o), .pim_mode_o(pim_mode_o), .exec_cnt_o(exec_cnt_o),
        .row_addr7_o(row_addr7_o), .col_addr9_o(col_addr9_o),
        .out_rd_en_o(out_rd_en_o), .done_o(done_o), .busy_o(busy_o),
        .fifo_count_o(fifo_count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] mode;
        logic [6:0] row;
        logic [8:0] col;
    } cmd_t;

    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   done_cyc = 0;
    int   phase = 0;
    int   run = 0;
    bit   mon_en = 1'b0;
    bit   gap_en = 1'b0;
    bit   fifo_nz_at_done = 1'b0;
    cmd_t cur;
    cmd_t exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int steps_for(input logic [2:0] m);
        case (m)
            3'd3:    return STEPS_READ;
            3'd4:    return STEPS_MAC;
            default: return STEPS_PGM;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

    task automatic finish_cmd();
        n_done++;
        done_cyc = cyc;
        fifo_nz_at_done = (fifo_count_o != 5'd0);
        phase = 0;
    endtask

    // Transaction monitor: each EXEC burst must match the next expected command.
    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            check("ready_vs_count", cmd_ready_o, 32'(fifo_count_o < FIFO_DEPTH));
            case (phase)
                0: begin
                    if (done_o) check("spurious_done", done_o, 0);
                    if (out_rd_en_o) check("spurious_rd", out_rd_en_o, 0);
                    if (pim_en_o) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_exec", pim_en_o, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("exec_mode", pim_mode_o, cur.mode);
                            check("exec_row", row_addr7_o, cur.row);
                            check("exec_col", col_addr9_o, cur.col);
                            check("exec_cnt0", exec_cnt_o, 0);
                            if (gap_en && fifo_nz_at_done) check("idle_gap", cyc - done_cyc, 2);
                            run = 1;
                            phase = 1;
                        end
                    end
                end
                1: begin
                    if (pim_en_o) begin
                        check("exec_cnt", exec_cnt_o, run);
                        check("mode_hold", pim_mode_o, cur.mode);
                        run++;
                    end else begin
                        check("steps", run, steps_for(cur.mode));
                        if (cur.mode == 3'd3 || cur.mode == 3'd4) begin
                            check("drain_rd", out_rd_en_o, 1);
                            check("drain_nodone", done_o, 0);
                            phase = 2;
                        end else begin
                            check("done_pgm", done_o, 1);
                            finish_cmd();
                        end
                    end
                end
                default: begin
                    check("done_rd", done_o, 1);
                    check("rd_single", out_rd_en_o, 0);
                    finish_cmd();
                end
            endcase
        end
    end

    task automatic push(input logic [2:0] m, input logic [6:0] r, input logic [8:0] c,
                        input bit enq, output logic rdy);
        @(negedge clk_i);
        rdy = cmd_ready_o;
        cmd_valid_i = 1'b1;
        cmd_mode_i = m;
        cmd_row_i = r;
        cmd_col_i = c;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        if (enq) exp_q.push_back('{mode: m, row: r, col: c});
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (n_done < target && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, n_done, target);
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        err_clr_i = 1'b1;
        @(posedge clk_i);
        #1 err_clr_i = 1'b0;
        @(negedge clk_i);
        check("err_cleared", err_o, 0);
    endtask

    task automatic mon_start(input bit gap);
        exp_q.delete();
        phase = 0;
        fifo_nz_at_done = 1'b0;
        gap_en = gap;
        mon_en = 1'b1;
    endtask

    // READ row 5 col 17 into an idle block, checked cycle by cycle.
    task automatic read_latency();
        logic rdy;
        push(3'd3, 7'd5, 9'd17, 1'b0, rdy);
        @(negedge clk_i);
        check("lat_count1", fifo_count_o, 1);
        check("lat_busy0", busy_o, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_i);
            if (k <= 4) begin
                check("lat_en", pim_en_o, 1);
                check("lat_cnt", exec_cnt_o, k - 1);
                check("lat_mode", pim_mode_o, 3);
                check("lat_row", row_addr7_o, 5);
                check("lat_col", col_addr9_o, 17);
            end else if (k == 5) begin
                check("lat_drain_en", pim_en_o, 0);
                check("lat_drain_rd", out_rd_en_o, 1);
                check("lat_drain_done", done_o, 0);
            end else if (k == 6) begin
                check("lat_done", done_o, 1);
                check("lat_done_rd", out_rd_en_o, 0);
                check("lat_done_busy", busy_o, 1);
            end else begin
                check("lat_idle_busy", busy_o, 0);
                check("lat_idle_done", done_o, 0);
                check("lat_idle_mode", pim_mode_o, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rdy;
        logic [2:0] modes [5];
        int         base, n, pushed, n_legal, n_ill, pick;
        logic [2:0] m;
        bit         seen;

        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_mode_i = '0; cmd_row_i = '0; cmd_col_i = '0;
        inbuf_full_i = 1'b1; abort_i = 1'b0; err_clr_i = 1'b0;

        #12;
        check("rst_ready", cmd_ready_o, 1);
        check("rst_en", pim_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_count", fifo_count_o, 0);
        check("rst_err", err_o, 0);
        check("rst_done", done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        read_latency();

        // Burst of five behind a waiting MAC: four fit, the fifth is refused.
        mon_start(1'b1);
        base = n_done;
        inbuf_full_i = 1'b0;
        push(3'd4, 7'd1, 9'd2, 1'b1, rdy);
        modes[0] = 3'd1; modes[1] = 3'd2; modes[2] = 3'd3; modes[3] = 3'd4; modes[4] = 3'd1;
        for (int i = 0; i < 5; i++) begin
            push(modes[i], 7'(10 + i), 9'(100 + i), i < 4, rdy);
            check("burst_ready", rdy, 32'(i < 4));
        end
        @(negedge clk_i);
        check("burst_count", fifo_count_o, 4);
        inbuf_full_i = 1'b1;
        wait_done(base + 5, "burst_done");
        check("burst_q_empty", exp_q.size(), 0);
        gap_en = 1'b0;

        // MAC held in WAIT_IN for 10 cycles, then released.
        base = n_done;
        inbuf_full_i = 1'b0;
        push(3'd4, 7'd3, 9'd33, 1'b1, rdy);
        repeat (10) @(negedge clk_i);
        check("wait_no_en", pim_en_o, 0);
        check("wait_busy", busy_o, 1);
        inbuf_full_i = 1'b1;
        wait_done(base + 1, "mac_wait_done");

        // MAC timeout: dropped with err, never executed.
        inbuf_full_i = 1'b0;
        push(3'd4, 7'd4, 9'd44, 1'b0, rdy);
        n = 0;
        while (n < 400) begin
            @(negedge clk_i);
            if (err_o) break;
            n++;
        end
        check("timeout_cycles", n, WAIT_TIMEOUT + 1);
        check("timeout_err", err_o, 1);
        check("timeout_busy", busy_o, 0);
        inbuf_full_i = 1'b1;
        pulse_clr();

        // Illegal mode between two READs.
        base = n_done;
        push(3'd3, 7'd10, 9'd100, 1'b1, rdy);
        push(3'd6, 7'd0, 9'd0, 1'b0, rdy);
        push(3'd3, 7'd11, 9'd200, 1'b1, rdy);
        wait_done(base + 2, "illegal_reads_done");
        check("illegal_err", err_o, 1);
        pulse_clr();

        // Set and clear on the same edge: set wins.
        push(3'd7, 7'd0, 9'd0, 1'b0, rdy);
        err_clr_i = 1'b1;
        @(posedge clk_i);
        #1 err_clr_i = 1'b0;
        @(negedge clk_i);
        check("err_set_wins", err_o, 1);
        repeat (2) @(negedge clk_i);
        mon_en = 1'b0;

        // Abort at exec_cnt 2 of a PGM with three queued; err stays set.
        push(3'd1, 7'd20, 9'd20, 1'b0, rdy);
        push(3'd3, 7'd21, 9'd21, 1'b0, rdy);
        push(3'd3, 7'd22, 9'd22, 1'b0, rdy);
        push(3'd3, 7'd23, 9'd23, 1'b0, rdy);
        n = 0;
        while (!(pim_en_o && exec_cnt_o == 4'd2) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("abort_pre_cnt", exec_cnt_o, 2);
        check("abort_pre_count", fifo_count_o, 3);
        abort_i = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_mode_i = 3'd3;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("abort_en", pim_en_o, 0);
        check("abort_count", fifo_count_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_mode", pim_mode_o, 0);
        check("abort_err_kept", err_o, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (done_o || pim_en_o || out_rd_en_o) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);

        // Asynchronous reset in the middle of EXEC.
        push(3'd3, 7'd1, 9'd1, 1'b0, rdy);
        @(negedge clk_i);
        @(negedge clk_i);
        check("prerst_en", pim_en_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_en", pim_en_o, 0);
        check("arst_ready", cmd_ready_o, 1);
        check("arst_count", fifo_count_o, 0);
        check("arst_err", err_o, 0);
        check("arst_mode", pim_mode_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        read_latency();

        // Randomized stream with random inbuf readiness.
        mon_start(1'b0);
        base = n_done;
        pushed = 0; n_legal = 0; n_ill = 0;
        for (int it = 0; it < 3000 && pushed < 40; it++) begin
            @(negedge clk_i);
            inbuf_full_i = 1'($urandom_range(0, 1));
            if (cmd_ready_o && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    pick = $urandom_range(4, 7);
                    m = (pick == 4) ? 3'd0 : 3'(pick);
                end else begin
                    m = 3'($urandom_range(1, 4));
                end
                cmd_valid_i = 1'b1;
                cmd_mode_i = m;
                cmd_row_i = 7'($urandom);
                cmd_col_i = 9'($urandom);
                if (is_legal(m)) begin
                    exp_q.push_back('{mode: m, row: cmd_row_i, col: cmd_col_i});
                    n_legal++;
                end else begin
                    n_ill++;
                end
                pushed++;
                @(posedge clk_i);
                #1 cmd_valid_i = 1'b0;
            end
        end
        for (int it = 0; it < 3000 && n_done < base + n_legal; it++) begin
            @(negedge clk_i);
            inbuf_full_i = 1'($urandom_range(0, 1));
        end
        check("rand_done", n_done, base + n_legal);
        repeat (3) @(negedge clk_i);
        check("rand_err", err_o, 32'(n_ill > 0));
        check("rand_busy", busy_o, 0);
        check("rand_q_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
